// File: rtl/gpp_comm_pkg.sv
// Shared constants and types for the GPP <-> communications-processor mailbox.
package gpp_comm_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_DEPTH      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } out_state_e;

  // Bit positions inside err_flags = {rx_overflow, rx_underflow, tx_overflow}
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UDF = 1;
  localparam int ERR_RX_OVF = 2;

endpackage

// File: rtl/comm_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty decoded from a registered
// occupancy count, rejected pushes/pops leave state untouched.
module comm_fifo
  import gpp_comm_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the output is defined straight out of reset
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/gpp_comm_mailbox.sv
// Mailbox between a GPP and a communications processor: NUM_CH round-robin TX
// FIFOs feeding a one-word output register, plus a single RX FIFO.
//   state | meaning
//   IDLE  | output register empty, gpp_trf_cp low
//   HOLD  | output register offered to CP, stable until cp_rtr_gpp
module gpp_comm_mailbox
  import gpp_comm_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_CH     = DEF_NUM_CH,
  parameter  int DEPTH      = DEF_DEPTH,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] gpp_tx_data,
  input  logic [CH_W-1:0]       gpp_tx_ch,
  input  logic                  gpp_tx_push,
  output logic [NUM_CH-1:0]     gpp_tx_full,
  output logic [DATA_WIDTH-1:0] gpp_rx_data,
  input  logic                  gpp_rx_pop,
  output logic                  data_rx_flag,
  output logic [DATA_WIDTH-1:0] cp_tx_data,
  output logic [CH_W-1:0]       cp_tx_ch,
  output logic                  gpp_trf_cp,
  input  logic                  cp_rtr_gpp,
  input  logic [DATA_WIDTH-1:0] cp_rx_data,
  input  logic                  cp_trf_gpp,
  output logic                  gpp_rtr_cp,
  output logic [2:0]            err_flags
);

  logic [DATA_WIDTH-1:0] tx_head [NUM_CH];
  logic [NUM_CH-1:0]     tx_req;
  logic [NUM_CH-1:0]     tx_pop;
  logic [NUM_CH-1:0]     tx_empty;
  logic [CH_W-1:0]       last_served;
  logic [CH_W-1:0]       grant;
  logic [CH_W-1:0]       grant_hi;
  logic [CH_W-1:0]       grant_lo;
  logic                  found_hi;
  logic                  any_ne;
  logic                  load;
  out_state_e            state;
  logic                  rx_full;
  logic                  rx_empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_tx
    assign tx_req[g] = gpp_tx_push && (gpp_tx_ch == CH_W'(g));
    assign tx_pop[g] = load && (grant == CH_W'(g));

    comm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_data (gpp_tx_data),
      .push    (tx_req[g]),
      .pop     (tx_pop[g]),
      .rd_data (tx_head[g]),
      .full    (gpp_tx_full[g]),
      .empty   (tx_empty[g])
    );
  end

  // Lowest non-empty channel above last_served wins; otherwise wrap to the lowest overall
  always_comb begin
    any_ne   = 1'b0;
    found_hi = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (!tx_empty[i]) begin
        any_ne   = 1'b1;
        grant_lo = CH_W'(i);
        if (CH_W'(i) > last_served) begin
          found_hi = 1'b1;
          grant_hi = CH_W'(i);
        end
      end
    end
    grant = found_hi ? grant_hi : grant_lo;
  end

  assign load = any_ne && ((state == ST_IDLE) || cp_rtr_gpp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      gpp_trf_cp  <= 1'b0;
      cp_tx_data  <= '0;
      cp_tx_ch    <= '0;
      last_served <= CH_W'(NUM_CH - 1);
    end else if (load) begin
      state       <= ST_HOLD;
      gpp_trf_cp  <= 1'b1;
      cp_tx_data  <= tx_head[grant];
      cp_tx_ch    <= grant;
      last_served <= grant;
    end else if (state == ST_HOLD && cp_rtr_gpp) begin
      state      <= ST_IDLE;
      gpp_trf_cp <= 1'b0;
    end
  end

  comm_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (cp_rx_data),
    .push    (cp_trf_gpp),
    .pop     (gpp_rx_pop),
    .rd_data (gpp_rx_data),
    .full    (rx_full),
    .empty   (rx_empty)
  );

  assign gpp_rtr_cp   = !rx_full;
  assign data_rx_flag = !rx_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_flags <= '0;
    end else begin
      if (|(tx_req & gpp_tx_full))    err_flags[ERR_TX_OVF] <= 1'b1;
      if (gpp_rx_pop && rx_empty)     err_flags[ERR_RX_UDF] <= 1'b1;
      if (cp_trf_gpp && rx_full)      err_flags[ERR_RX_OVF] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpp_comm_mailbox.sv
// Self-checking bench: directed scenarios plus a randomized run scored against
// per-channel reference queues.
module tb_gpp_comm_mailbox;

  localparam int DW  = 16;
  localparam int NCH = 2;
  localparam int DEP = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [DW-1:0]  gpp_tx_data;
  logic [0:0]     gpp_tx_ch;
  logic           gpp_tx_push;
  logic [NCH-1:0] gpp_tx_full;
  logic [DW-1:0]  gpp_rx_data;
  logic           gpp_rx_pop;
  logic           data_rx_flag;
  logic [DW-1:0]  cp_tx_data;
  logic [0:0]     cp_tx_ch;
  logic           gpp_trf_cp;
  logic           cp_rtr_gpp;
  logic [DW-1:0]  cp_rx_data;
  logic           cp_trf_gpp;
  logic           gpp_rtr_cp;
  logic [2:0]     err_flags;

  int n_tests = 0;
  int n_fail  = 0;

  gpp_comm_mailbox #(.DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(DEP)) dut (
    .clk          (clk),
    .rst          (rst),
    .gpp_tx_data  (gpp_tx_data),
    .gpp_tx_ch    (gpp_tx_ch),
    .gpp_tx_push  (gpp_tx_push),
    .gpp_tx_full  (gpp_tx_full),
    .gpp_rx_data  (gpp_rx_data),
    .gpp_rx_pop   (gpp_rx_pop),
    .data_rx_flag (data_rx_flag),
    .cp_tx_data   (cp_tx_data),
    .cp_tx_ch     (cp_tx_ch),
    .gpp_trf_cp   (gpp_trf_cp),
    .cp_rtr_gpp   (cp_rtr_gpp),
    .cp_rx_data   (cp_rx_data),
    .cp_trf_gpp   (cp_trf_gpp),
    .gpp_rtr_cp   (gpp_rtr_cp),
    .err_flags    (err_flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    gpp_tx_data = '0;
    gpp_tx_ch   = '0;
    gpp_tx_push = 1'b0;
    gpp_rx_pop  = 1'b0;
    cp_rtr_gpp  = 1'b0;
    cp_rx_data  = '0;
    cp_trf_gpp  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic push_word(input int ch, input logic [DW-1:0] d);
    gpp_tx_ch   = 1'(ch);
    gpp_tx_data = d;
    gpp_tx_push = 1'b1;
    step();
    gpp_tx_push = 1'b0;
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_trf"},     32'(gpp_trf_cp),   32'd0);
    chk({pfx, "_cpdata"},  32'(cp_tx_data),   32'd0);
    chk({pfx, "_cpch"},    32'(cp_tx_ch),     32'd0);
    chk({pfx, "_full"},    32'(gpp_tx_full),  32'd0);
    chk({pfx, "_rxflag"},  32'(data_rx_flag), 32'd0);
    chk({pfx, "_rxdata"},  32'(gpp_rx_data),  32'd0);
    chk({pfx, "_rtr"},     32'(gpp_rtr_cp),   32'd1);
    chk({pfx, "_err"},     32'(err_flags),    32'd0);
  endtask

  task automatic test_latency();
    do_reset();
    cp_rtr_gpp = 1'b1;
    push_word(0, 16'h1111);
    chk("lat_n1_trf", 32'(gpp_trf_cp), 32'd0);
    step();
    chk("lat_n2_trf",  32'(gpp_trf_cp), 32'd1);
    chk("lat_n2_data", 32'(cp_tx_data), 32'h1111);
    chk("lat_n2_ch",   32'(cp_tx_ch),   32'd0);
    step();
    chk("lat_n3_trf", 32'(gpp_trf_cp), 32'd0);
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] exp_seq [8];
    exp_seq = '{16'hA0, 16'hB0, 16'hA1, 16'hB1, 16'hA2, 16'hB2, 16'hA3, 16'hB3};
    do_reset();
    for (int k = 0; k < 4; k++) push_word(0, DW'(16'hA0 + k));
    for (int k = 0; k < 4; k++) push_word(1, DW'(16'hB0 + k));
    step();
    cp_rtr_gpp = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("rr_trf",  32'(gpp_trf_cp), 32'd1);
      chk("rr_data", 32'(cp_tx_data), 32'(exp_seq[k]));
      step();
    end
    chk("rr_done_trf", 32'(gpp_trf_cp), 32'd0);
  endtask

  task automatic test_hold();
    do_reset();
    push_word(0, 16'h00C3);
    push_word(0, 16'h00D4);
    step();
    for (int k = 0; k < 10; k++) begin
      chk("hold_data", 32'(cp_tx_data), 32'h00C3);
      chk("hold_trf",  32'(gpp_trf_cp), 32'd1);
      step();
    end
    cp_rtr_gpp = 1'b1;
    step();
    chk("hold_next_data", 32'(cp_tx_data), 32'h00D4);
    chk("hold_next_trf",  32'(gpp_trf_cp), 32'd1);
    step();
    chk("hold_end_trf", 32'(gpp_trf_cp), 32'd0);
  endtask

  task automatic test_rx_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      chk("rxo_rtr_before", 32'(gpp_rtr_cp), 32'd1);
      cp_trf_gpp = 1'b1;
      cp_rx_data = DW'(16'h0100 + k);
      step();
      cp_trf_gpp = 1'b0;
      if (k == 0) begin
        chk("rxo_flag_first", 32'(data_rx_flag), 32'd1);
        chk("rxo_head_first", 32'(gpp_rx_data),  32'h0100);
      end
    end
    chk("rxo_rtr_full", 32'(gpp_rtr_cp), 32'd0);
    chk("rxo_err_pre",  32'(err_flags),  32'd0);
    cp_trf_gpp = 1'b1;
    cp_rx_data = 16'h5555;
    step();
    cp_trf_gpp = 1'b0;
    chk("rxo_err", 32'(err_flags), 32'b100);
    for (int k = 0; k < 4; k++) begin
      chk("rxo_pop_flag", 32'(data_rx_flag), 32'd1);
      chk("rxo_pop_data", 32'(gpp_rx_data),  32'(16'h0100 + k));
      gpp_rx_pop = 1'b1;
      step();
      gpp_rx_pop = 1'b0;
    end
    chk("rxo_empty_flag", 32'(data_rx_flag), 32'd0);
    chk("rxo_rtr_after",  32'(gpp_rtr_cp),   32'd1);
    chk("rxo_err_after",  32'(err_flags),    32'b100);
  endtask

  task automatic test_tx_overflow();
    logic [DW-1:0] exp_seq [5];
    logic [0:0]    exp_ch  [5];
    exp_seq = '{16'h0E00, 16'hB100, 16'hB101, 16'hB102, 16'hB103};
    exp_ch  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    push_word(0, 16'h0E00);
    step();
    step();
    for (int k = 0; k < 4; k++) push_word(1, DW'(16'hB100 + k));
    chk("txo_full1", 32'(gpp_tx_full[1]), 32'd1);
    chk("txo_full0", 32'(gpp_tx_full[0]), 32'd0);
    chk("txo_err_pre", 32'(err_flags), 32'd0);
    push_word(1, 16'h0BAD);
    chk("txo_err", 32'(err_flags), 32'b001);
    chk("txo_full1_after", 32'(gpp_tx_full[1]), 32'd1);
    cp_rtr_gpp = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("txo_drain_trf",  32'(gpp_trf_cp), 32'd1);
      chk("txo_drain_data", 32'(cp_tx_data), 32'(exp_seq[k]));
      chk("txo_drain_ch",   32'(cp_tx_ch),   32'(exp_ch[k]));
      step();
    end
    chk("txo_drain_end", 32'(gpp_trf_cp), 32'd0);
    gpp_rx_pop = 1'b1;
    step();
    gpp_rx_pop = 1'b0;
    chk("udf_err", 32'(err_flags), 32'b011);
  endtask

  task automatic test_reset_in_hold();
    int emitted;
    do_reset();
    gpp_rx_pop = 1'b1;
    step();
    gpp_rx_pop = 1'b0;
    chk("rsth_err_set", 32'(err_flags), 32'b010);
    push_word(0, 16'h4400);
    push_word(0, 16'h4401);
    push_word(1, 16'h4410);
    cp_trf_gpp = 1'b1;
    cp_rx_data = 16'h7777;
    step();
    cp_trf_gpp = 1'b0;
    chk("rsth_hold_trf",  32'(gpp_trf_cp),   32'd1);
    chk("rsth_hold_rxfl", 32'(data_rx_flag), 32'd1);
    rst        = 1'b0;
    cp_rtr_gpp = 1'b1;
    step();
    rst = 1'b1;
    check_reset_values("rsth");
    emitted = 0;
    for (int k = 0; k < 10; k++) begin
      if (gpp_trf_cp) emitted++;
      step();
    end
    chk("rsth_no_emit", 32'(emitted), 32'd0);
  endtask

  task automatic test_random();
    logic [DW-1:0] txq [NCH][$];
    logic [DW-1:0] rxq [$];
    logic [DW-1:0] d;
    int            ch;
    int            sz;
    int            budget;
    int            left;
    bit            rtr;
    bit            do_pop;
    bit            do_send;
    do_reset();
    for (int cyc = 0; cyc < 500; cyc++) begin
      chk("rnd_rtr",  32'(gpp_rtr_cp),   32'(rxq.size() < DEP));
      chk("rnd_flag", 32'(data_rx_flag), 32'(rxq.size() > 0));
      if (rxq.size() > 0) chk("rnd_rx_head", 32'(gpp_rx_data), 32'(rxq[0]));

      rtr = (cyc < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cp_rtr_gpp = rtr;
      if (gpp_trf_cp && rtr) begin
        ch = int'(cp_tx_ch);
        sz = txq[ch].size();
        chk("rnd_cp_src_nonempty", 32'(sz > 0), 32'd1);
        if (sz > 0) chk("rnd_cp_word", 32'(cp_tx_data), 32'(txq[ch].pop_front()));
      end

      ch = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 3) != 0 && txq[ch].size() < DEP) begin
        chk("rnd_tx_not_full", 32'(gpp_tx_full[ch]), 32'd0);
        d           = DW'($urandom);
        gpp_tx_ch   = 1'(ch);
        gpp_tx_data = d;
        gpp_tx_push = 1'b1;
        txq[ch].push_back(d);
      end else begin
        gpp_tx_push = 1'b0;
      end

      do_pop  = (rxq.size() > 0) && ($urandom_range(0, 2) == 0);
      do_send = (rxq.size() < DEP) && ($urandom_range(0, 1) == 1);
      gpp_rx_pop = do_pop;
      cp_trf_gpp = do_send;
      d          = DW'($urandom);
      cp_rx_data = d;
      if (do_pop)  void'(rxq.pop_front());
      if (do_send) rxq.push_back(d);
      step();
    end
    idle_inputs();
    cp_rtr_gpp = 1'b1;
    budget = 0;
    left   = txq[0].size() + txq[1].size();
    while (left > 0 && budget < 40) begin
      if (gpp_trf_cp) begin
        ch = int'(cp_tx_ch);
        sz = txq[ch].size();
        chk("drain_src_nonempty", 32'(sz > 0), 32'd1);
        if (sz > 0) chk("drain_word", 32'(cp_tx_data), 32'(txq[ch].pop_front()));
      end
      step();
      budget++;
      left = txq[0].size() + txq[1].size();
    end
    chk("drain_left", 32'(left), 32'd0);
    chk("drain_idle", 32'(gpp_trf_cp), 32'd0);
    while (rxq.size() > 0) begin
      chk("drain_rx_data", 32'(gpp_rx_data), 32'(rxq.pop_front()));
      gpp_rx_pop = 1'b1;
      step();
      gpp_rx_pop = 1'b0;
    end
    chk("drain_rx_flag", 32'(data_rx_flag), 32'd0);
    chk("rnd_err", 32'(err_flags), 32'd0);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    check_reset_values("rst");
    test_latency();
    test_round_robin();
    test_hold();
    test_rx_overflow();
    test_tx_overflow();
    test_reset_in_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpp_comm_mailbox.md
GPP_COMM_MAILBOX -- requirements
Module: gpp_comm_mailbox

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of every data word.
REQ-002 Parameter NUM_CH, default 2: number of GPP transmit channels (1..8).
REQ-003 Parameter DEPTH, default 4: words per FIFO (power of two, >=2).
REQ-004 Port clk  input  1  single system clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset; synchronous, active-low.
REQ-006 Port gpp_tx_data  input  DATA_WIDTH  word the GPP pushes.
REQ-007 Port gpp_tx_ch  input  $clog2(NUM_CH) (min 1)  target TX channel of the push.
REQ-008 Port gpp_tx_push  input  1  push strobe.
REQ-009 Port gpp_tx_full  output  NUM_CH  per-channel full flag.
REQ-010 Port gpp_rx_data  output  DATA_WIDTH  head of RX FIFO (first-word-fall-through).
REQ-011 Port gpp_rx_pop  input  1  pop strobe.
REQ-012 Port data_rx_flag  output  1  RX FIFO non-empty.
REQ-013 Port cp_tx_data  output  DATA_WIDTH  word offered to the communications processor.
REQ-014 Port cp_tx_ch  output  $clog2(NUM_CH) (min 1)  source channel of cp_tx_data.
REQ-015 Port gpp_trf_cp  output  1  transfer valid toward CP.
REQ-016 Port cp_rtr_gpp  input  1  CP ready to receive.
REQ-017 Port cp_rx_data  input  DATA_WIDTH  word from CP.
REQ-018 Port cp_trf_gpp  input  1  CP transfer valid.
REQ-019 Port gpp_rtr_cp  output  1  RX FIFO not full.
REQ-020 Port err_flags  output  3  sticky {rx_overflow, rx_underflow, tx_overflow}.

Function
REQ-021 A word moves GPP->CP only in a cycle with gpp_trf_cp=1 and cp_rtr_gpp=1; moves CP->RX FIFO only with cp_trf_gpp=1 and gpp_rtr_cp=1.
REQ-022 Output stage FSM states: IDLE (gpp_trf_cp=0), HOLD (gpp_trf_cp=1).
REQ-023 IDLE: if any TX channel non-empty, pop granted channel into output register, go HOLD; else stay IDLE.
REQ-024 HOLD: cp_tx_data/cp_tx_ch stable until handshake; on handshake, if any channel non-empty, load next grant same cycle (stay HOLD, back-to-back throughput 1 word/cycle), else go IDLE.
REQ-025 Arbitration round-robin: grant first non-empty channel strictly after last-served channel, wrapping NUM_CH-1 -> 0; last-served resets to NUM_CH-1 so channel 0 has first priority.
REQ-026 Latency: push into empty FIFO with output stage IDLE at cycle N -> gpp_trf_cp=1 at cycle N+2.
REQ-027 Per-channel word order preserved; no word duplicated or lost except by REQ-029.
REQ-028 Full/empty from registered occupancy counts (width $clog2(DEPTH)+1); pointers wrap modulo DEPTH.
REQ-029 Push to full TX channel ignored, sets tx_overflow; CP write while full cannot occur (gpp_rtr_cp=0) but if cp_trf_gpp asserted with gpp_rtr_cp=0 the word is dropped and rx_overflow set.
REQ-030 gpp_rx_pop on empty RX FIFO ignored, sets rx_underflow.
REQ-031 Simultaneous push and pop on same FIFO when neither full nor empty: both take effect, count unchanged; when full, push still rejected even with concurrent pop.
REQ-032 data_rx_flag visible one cycle after the accepting CP handshake; gpp_rx_data valid whenever data_rx_flag=1.
REQ-033 err_flags cleared only by reset.

Reset
REQ-034 When rst=0 at a rising edge: all FIFOs empty, FSM IDLE, last-served=NUM_CH-1, err_flags=0.
REQ-035 Reset values: gpp_trf_cp=0, cp_tx_data=0, cp_tx_ch=0, gpp_tx_full=0, data_rx_flag=0, gpp_rx_data=0, gpp_rtr_cp=1 from first cycle after reset release.
REQ-036 Reset mid-transfer (HOLD) discards held word and all FIFO contents; no handshake completes in the reset cycle.

Structure
REQ-037 Package gpp_comm_pkg holds default DATA_WIDTH/NUM_CH/DEPTH constants, FSM state enum, and err_flags bit-index constants.
REQ-038 One sub-module comm_fifo (parametrised sync FIFO, FWFT, count/full/empty), instantiated NUM_CH+1 times.

Verification
REQ-039 Push 0x1111 ch0 at cycle 5, cp_rtr_gpp=1 -> gpp_trf_cp=1, cp_tx_data=0x1111, cp_tx_ch=0 at cycle 7, one cycle only.
REQ-040 Fill ch0 with 0xA0..A3 and ch1 with 0xB0..B3, cp_rtr_gpp=1 -> CP sequence A0,B0,A1,B1,A2,B2,A3,B3 on consecutive cycles.
REQ-041 cp_rtr_gpp=0 for 10 cycles while HOLD with 0x00C3 -> cp_tx_data held 0x00C3; handshake on rtr rise, next word follows next cycle.
REQ-042 CP sends 5 words with DEPTH=4, no pops -> gpp_rtr_cp=0 after 4th; forced 5th sets err_flags=3'b100; pop order equals send order.
REQ-043 Fifth push to ch1 when full -> gpp_tx_full[1]=1, word discarded, err_flags[0]=1; pop on empty RX -> err_flags[1]=1.
REQ-044 rst=0 for one cycle during HOLD with words queued -> next cycle gpp_trf_cp=0, all flags at reset values, no queued word ever emitted.
